// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer and the CSR unit:
// FSM state encoding, next-PC source codes, bus-error cause and
// the latch-control bundle with its canned settings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    localparam logic [1:0] PCSEL_SEQ   = 2'd0;
    localparam logic [1:0] PCSEL_BR    = 2'd1;
    localparam logic [1:0] PCSEL_MTVEC = 2'd2;
    localparam logic [1:0] PCSEL_MEPC  = 2'd3;

    // Exception cause reported to the CSR unit when a data access times out
    localparam logic [3:0] EXC_BUS_ERR = 4'd5;

    typedef struct packed {
        logic       en_pc;
        logic       en_if_id;
        logic       en_id_ex;
        logic       en_ex_mem;
        logic       en_mem_wb;
        logic       flush_if_id;
        logic       flush_id_ex;
        logic       flush_ex_mem;
        logic       flush_mem_wb;
        logic [1:0] pc_sel;
        logic       bus_err;
    } ctrl_t;

    // Free-running pipeline: everything advances, sequential fetch
    function automatic ctrl_t ctrl_pass();
        ctrl_t c;
        c           = '0;
        c.en_pc     = 1'b1;
        c.en_if_id  = 1'b1;
        c.en_id_ex  = 1'b1;
        c.en_ex_mem = 1'b1;
        c.en_mem_wb = 1'b1;
        c.pc_sel    = PCSEL_SEQ;
        return c;
    endfunction

    // Trap entry/return: squash every younger instruction, redirect PC
    function automatic ctrl_t ctrl_trap(input logic [1:0] sel);
        ctrl_t c;
        c              = ctrl_pass();
        c.flush_if_id  = 1'b1;
        c.flush_id_ex  = 1'b1;
        c.flush_ex_mem = 1'b1;
        c.flush_mem_wb = 1'b1;
        c.pc_sel       = sel;
        return c;
    endfunction

    // Data-memory wait: freeze up to EX/MEM, feed bubbles into WB
    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c              = ctrl_pass();
        c.en_pc        = 1'b0;
        c.en_if_id     = 1'b0;
        c.en_id_ex     = 1'b0;
        c.en_ex_mem    = 1'b0;
        c.flush_mem_wb = 1'b1;
        return c;
    endfunction

    // Taken branch: kill the two wrong-path instructions
    function automatic ctrl_t ctrl_branch();
        ctrl_t c;
        c             = ctrl_pass();
        c.flush_if_id = 1'b1;
        c.flush_id_ex = 1'b1;
        c.pc_sel      = PCSEL_BR;
        return c;
    endfunction

    // Load-use: hold fetch/decode, bubble into EX
    function automatic ctrl_t ctrl_load_use();
        ctrl_t c;
        c             = ctrl_pass();
        c.en_pc       = 1'b0;
        c.en_if_id    = 1'b0;
        c.flush_id_ex = 1'b1;
        return c;
    endfunction

    // Cycle after a trap redirect: drop the fetch issued before the redirect
    function automatic ctrl_t ctrl_trap_exit();
        ctrl_t c;
        c             = ctrl_pass();
        c.flush_if_id = 1'b1;
        c.flush_id_ex = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the sequencer.
// master = datapath side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;

    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic       use_rs1_ID;
    logic       use_rs2_ID;
    logic [4:0] rd_EX;
    logic       MemRead_EX;
    logic       branch_taken_EX;
    logic       mem_req_MEM;
    logic       mem_ack;
    logic [3:0] exp_vector_MEM;
    logic       mret_MEM;

    logic       en_PC;
    logic       en_IF_ID;
    logic       en_ID_EX;
    logic       en_EX_MEM;
    logic       en_MEM_WB;
    logic       flush_IF_ID;
    logic       flush_ID_EX;
    logic       flush_EX_MEM;
    logic       flush_MEM_WB;
    logic [1:0] pc_sel;
    logic       bus_err;

    modport master (
        output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX,
               branch_taken_EX, mem_req_MEM, mem_ack, exp_vector_MEM, mret_MEM,
        input  en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_sel, bus_err
    );

    modport slave (
        input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_EX, MemRead_EX,
               branch_taken_EX, mem_req_MEM, mem_ack, exp_vector_MEM, mret_MEM,
        output en_PC, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
               flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB,
               pc_sel, bus_err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the
// instruction in ID. x0 never creates a dependency.
module hazard_detect (
    input  logic [4:0] rs1_ID,
    input  logic [4:0] rs2_ID,
    input  logic       use_rs1_ID,
    input  logic       use_rs2_ID,
    input  logic [4:0] rd_EX,
    input  logic       MemRead_EX,
    output logic       load_use
);

    logic hit_rs1;
    logic hit_rs2;

    // Compare the load destination against each source actually read
    always_comb begin
        hit_rs1  = use_rs1_ID && (rs1_ID == rd_EX);
        hit_rs2  = use_rs2_ID && (rs2_ID == rd_EX);
        load_use = MemRead_EX && (rd_EX != 5'd0) && (hit_rs1 || hit_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five-stage pipeline latches: enables,
// bubbles, next-PC source, memory-timeout trap and performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    state_t            state, state_nx;
    logic [WCNT_W-1:0] wcnt, wcnt_nx;

    logic   load_use;
    logic   exc_pend;
    logic   trap_req;
    logic   mem_stall;
    ctrl_t  run_ctrl;
    state_t run_nx;
    logic   run_wload;
    ctrl_t  ctrl;

    hazard_detect u_hazard_detect (
        .rs1_ID     (hz.rs1_ID),
        .rs2_ID     (hz.rs2_ID),
        .use_rs1_ID (hz.use_rs1_ID),
        .use_rs2_ID (hz.use_rs2_ID),
        .rd_EX      (hz.rd_EX),
        .MemRead_EX (hz.MemRead_EX),
        .load_use   (load_use)
    );

    // Priority decode of a normal running cycle (also reused on wait release)
    always_comb begin
        exc_pend  = (hz.exp_vector_MEM != 4'd0);
        trap_req  = exc_pend || hz.mret_MEM;
        mem_stall = hz.mem_req_MEM && !hz.mem_ack;
        run_ctrl  = ctrl_pass();
        run_nx    = ST_RUN;
        run_wload = 1'b0;
        if (trap_req) begin
            run_ctrl = ctrl_trap(exc_pend ? PCSEL_MTVEC : PCSEL_MEPC);
            run_nx   = ST_TRAP;
        end else if (mem_stall) begin
            run_ctrl  = ctrl_freeze();
            run_nx    = ST_MEM_WAIT;
            run_wload = 1'b1;
        end else if (hz.branch_taken_EX) begin
            run_ctrl = ctrl_branch();
        end else if (load_use) begin
            run_ctrl = ctrl_load_use();
        end
    end

    // Next-state, wait counter and latch-control selection per FSM state
    always_comb begin
        ctrl     = ctrl_pass();
        state_nx = state;
        wcnt_nx  = '0;
        unique case (state)
            ST_RUN: begin
                ctrl     = run_ctrl;
                state_nx = run_nx;
                wcnt_nx  = run_wload ? WCNT_W'(1) : '0;
            end
            ST_MEM_WAIT: begin
                if (hz.mem_ack) begin
                    ctrl     = run_ctrl;
                    state_nx = run_nx;
                end else if (wcnt >= WCNT_LAST) begin
                    ctrl         = ctrl_trap(PCSEL_MTVEC);
                    ctrl.bus_err = 1'b1;
                    state_nx     = ST_TRAP;
                end else begin
                    ctrl    = ctrl_freeze();
                    wcnt_nx = wcnt + WCNT_W'(1);
                end
            end
            ST_TRAP: begin
                ctrl     = ctrl_trap_exit();
                state_nx = ST_RUN;
            end
            default: begin
                ctrl     = ctrl_pass();
                state_nx = ST_RUN;
            end
        endcase
    end

    // Drive the latch-control outputs from the selected bundle
    always_comb begin
        hz.en_PC        = ctrl.en_pc;
        hz.en_IF_ID     = ctrl.en_if_id;
        hz.en_ID_EX     = ctrl.en_id_ex;
        hz.en_EX_MEM    = ctrl.en_ex_mem;
        hz.en_MEM_WB    = ctrl.en_mem_wb;
        hz.flush_IF_ID  = ctrl.flush_if_id;
        hz.flush_ID_EX  = ctrl.flush_id_ex;
        hz.flush_EX_MEM = ctrl.flush_ex_mem;
        hz.flush_MEM_WB = ctrl.flush_mem_wb;
        hz.pc_sel       = ctrl.pc_sel;
        hz.bus_err      = ctrl.bus_err;
    end

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    // Saturating stall / flush performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.en_pc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((ctrl.flush_if_id || ctrl.flush_id_ex ||
                 ctrl.flush_ex_mem || ctrl.flush_mem_wb) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
